// File: rtl/cmp_threshold_monitor.sv
// Registered threshold comparator (subtract-and-carry) with a debounced FLAG and RISE pulse.
// Latency: HIT 1 cycle after sample, FLAG/RISE 2 cycles; CMP_HYST_EN selects hysteresis clearing.
module cmp_threshold_monitor #(
    parameter int WIDTH = 8,
    parameter int HOLD  = 4
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_thr_we,
    input  logic [WIDTH-1:0] i_thr_in,
    input  logic [2:0]       i_mode,
    input  logic             i_a_valid,
    input  logic [WIDTH-1:0] i_a,
    output logic             o_hit_valid,
    output logic             o_hit,
    output logic             o_flag,
    output logic             o_rise
);
    localparam int CW = $clog2(HOLD + 1);
    localparam logic [CW-1:0] HOLD_C = CW'(HOLD);

    logic [WIDTH-1:0] r_thr;
    logic             r_hit_valid;
    logic             r_hit;
    logic             r_flag;
    logic             r_rise;
    logic [CW-1:0]    r_cnt;

    logic             w_signed;
    logic [WIDTH-1:0] w_a_x;
    logic [WIDTH-1:0] w_thr_x;
    logic [WIDTH-1:0] w_diff;
    logic             w_c;
    logic             w_z;
    logic             w_res;
    logic [CW-1:0]    w_cnt_inc;
    logic [CW-1:0]    w_cnt_hit;

    // Signed modes flip both MSBs so the unsigned carry chain orders two's-complement values.
    assign w_signed = (i_mode == 3'd6) || (i_mode == 3'd7);
    assign w_a_x    = {i_a[WIDTH-1] ^ w_signed, i_a[WIDTH-2:0]};
    assign w_thr_x  = {r_thr[WIDTH-1] ^ w_signed, r_thr[WIDTH-2:0]};
    assign {w_c, w_diff} = {1'b0, w_a_x} + {1'b0, ~w_thr_x} + {{WIDTH{1'b0}}, 1'b1};
    assign w_z = (w_diff == '0);

    always_comb begin
        w_res = 1'b0;
        case (i_mode)
            3'd0:    w_res = w_c & ~w_z;
            3'd1:    w_res = w_c;
            3'd2:    w_res = ~w_c;
            3'd3:    w_res = ~w_c | w_z;
            3'd4:    w_res = w_z;
            3'd5:    w_res = ~w_z;
            3'd6:    w_res = w_c & ~w_z;
            default: w_res = ~w_c;
        endcase
    end

    assign w_cnt_inc = (r_cnt == HOLD_C) ? HOLD_C : r_cnt + CW'(1);
`ifdef CMP_HYST_EN
    assign w_cnt_hit = r_flag ? HOLD_C : w_cnt_inc;
`else
    assign w_cnt_hit = w_cnt_inc;
`endif

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_thr       <= '0;
            r_hit_valid <= 1'b0;
            r_hit       <= 1'b0;
            r_flag      <= 1'b0;
            r_rise      <= 1'b0;
            r_cnt       <= '0;
        end else begin
            if (i_thr_we)
                r_thr <= i_thr_in;
            r_hit_valid <= i_a_valid;
            if (i_a_valid)
                r_hit <= w_res;
            r_rise <= 1'b0;
            if (r_hit_valid) begin
                if (r_hit) begin
                    r_cnt <= w_cnt_hit;
                    if (w_cnt_hit == HOLD_C) begin
                        r_flag <= 1'b1;
                        r_rise <= ~r_flag;
                    end
                end else begin
`ifdef CMP_HYST_EN
                    // While alarmed, each miss drains one step; the last step clears FLAG.
                    if (r_flag && (r_cnt > CW'(1))) begin
                        r_cnt <= r_cnt - CW'(1);
                    end else begin
                        r_cnt  <= '0;
                        r_flag <= 1'b0;
                    end
`else
                    r_cnt  <= '0;
                    r_flag <= 1'b0;
`endif
                end
            end
        end
    end

    assign o_hit_valid = r_hit_valid;
    assign o_hit       = r_hit;
    assign o_flag      = r_flag;
    assign o_rise      = r_rise;
endmodule

// File: tb/tb_cmp_threshold_monitor.sv
// Bench for cmp_threshold_monitor: directed scenarios plus random bursts, scored against a
// run-length reference model; expected results are queued at the clock edge and popped by a monitor.
module tb_cmp_threshold_monitor;
    localparam int W    = 8;
    localparam int HOLD = 4;

    logic         clk = 1'b0;
    logic         i_reset = 1'b1;
    logic         i_thr_we = 1'b0;
    logic [W-1:0] i_thr_in = '0;
    logic [2:0]   i_mode = '0;
    logic         i_a_valid = 1'b0;
    logic [W-1:0] i_a = '0;
    logic         o_hit_valid, o_hit, o_flag, o_rise;

    cmp_threshold_monitor #(.WIDTH(W), .HOLD(HOLD)) dut (
        .i_clk(clk), .i_reset(i_reset), .i_thr_we(i_thr_we), .i_thr_in(i_thr_in),
        .i_mode(i_mode), .i_a_valid(i_a_valid), .i_a(i_a),
        .o_hit_valid(o_hit_valid), .o_hit(o_hit), .o_flag(o_flag), .o_rise(o_rise)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic hit;
        logic flag;
        logic rise;
    } exp_t;

    exp_t exp_q[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic logic cmp_ref(input logic [2:0] mode, input logic [W-1:0] a, input logic [W-1:0] t);
        int ua, ut, sa, st;
        ua = int'(a);
        ut = int'(t);
        sa = (ua >= (1 << (W - 1))) ? ua - (1 << W) : ua;
        st = (ut >= (1 << (W - 1))) ? ut - (1 << W) : ut;
        case (mode)
            3'd0:    return ua > ut;
            3'd1:    return ua >= ut;
            3'd2:    return ua < ut;
            3'd3:    return ua <= ut;
            3'd4:    return ua == ut;
            3'd5:    return ua != ut;
            3'd6:    return sa > st;
            default: return sa < st;
        endcase
    endfunction

    // Reference model: hit streak length and alarm state, advanced once per valid sample.
    logic [W-1:0] m_thr = '0;
    int           m_run = 0;
    logic         m_flag = 1'b0;

    always @(posedge clk) begin
        exp_t e;
        if (i_reset) begin
            m_thr  = '0;
            m_run  = 0;
            m_flag = 1'b0;
            exp_q.delete();
        end else begin
            if (i_a_valid) begin
                e.hit  = cmp_ref(i_mode, i_a, m_thr);
                e.rise = 1'b0;
                if (e.hit) begin
`ifdef CMP_HYST_EN
                    m_run = m_flag ? HOLD : ((m_run + 1 > HOLD) ? HOLD : m_run + 1);
`else
                    m_run = (m_run + 1 > HOLD) ? HOLD : m_run + 1;
`endif
                    if (m_run == HOLD) begin
                        e.rise = !m_flag;
                        m_flag = 1'b1;
                    end
                end else begin
`ifdef CMP_HYST_EN
                    m_run = m_flag ? m_run - 1 : 0;
                    if (m_run <= 0) begin
                        m_run  = 0;
                        m_flag = 1'b0;
                    end
`else
                    m_run  = 0;
                    m_flag = 1'b0;
`endif
                end
                e.flag = m_flag;
                exp_q.push_back(e);
            end
            if (i_thr_we)
                m_thr = i_thr_in;
        end
    end

    logic rst_q   = 1'b0;
    logic started = 1'b0;
    always @(posedge clk) begin
        rst_q   <= i_reset;
        started <= 1'b1;
    end

    // Monitor: HIT checked when HIT_VALID shows, FLAG/RISE checked the following cycle.
    exp_t pend;
    logic pend_vld = 1'b0;
    logic cur_flag = 1'b0;
    logic last_hit = 1'b0;

    always @(negedge clk) begin
        if (started) begin
            if (rst_q) begin
                chk("rst_hit_valid", o_hit_valid, 0);
                chk("rst_hit", o_hit, 0);
                chk("rst_flag", o_flag, 0);
                chk("rst_rise", o_rise, 0);
                pend_vld = 1'b0;
                cur_flag = 1'b0;
                last_hit = 1'b0;
            end else begin
                if (pend_vld) begin
                    chk("flag", o_flag, pend.flag);
                    chk("rise", o_rise, pend.rise);
                    cur_flag = pend.flag;
                    pend_vld = 1'b0;
                end else begin
                    chk("flag_hold", o_flag, cur_flag);
                    chk("rise_idle", o_rise, 0);
                end
                if (o_hit_valid) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_hit_valid", 1, 0);
                    end else begin
                        pend = exp_q.pop_front();
                        chk("hit", o_hit, pend.hit);
                        last_hit = pend.hit;
                        pend_vld = 1'b1;
                    end
                end else begin
                    chk("hit_hold", o_hit, last_hit);
                end
            end
        end
    end

    logic [W-1:0] drv_thr = '0;

    task automatic drive(input logic rst, input logic we, input logic [W-1:0] thr_in,
                         input logic [2:0] mode, input logic vld, input logic [W-1:0] a);
        i_reset   = rst;
        i_thr_we  = we;
        i_thr_in  = thr_in;
        i_mode    = mode;
        i_a_valid = vld;
        i_a       = a;
        if (rst) drv_thr = '0;
        else if (we) drv_thr = thr_in;
        @(posedge clk);
        #2;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        logic [W-1:0] vals[3];
        logic [W-1:0] a;
        logic [2:0]   mode;
        vals[0] = 8'h7F;
        vals[1] = 8'h80;
        vals[2] = 8'h81;

        // Reset held with a valid all-ones sample; threshold must read back as zero.
        drive(1, 0, 0, 3'd1, 1, 8'hFF);
        drive(1, 1, 8'h55, 3'd1, 1, 8'hFF);
        drive(0, 0, 0, 3'd4, 1, 8'h00);
        idle(2);

        // All modes around the 8'h80 boundary, plus the all-ones/all-zeros equal limits.
        drive(0, 1, 8'h80, 0, 0, 0);
        for (int m = 0; m < 8; m++)
            for (int k = 0; k < 3; k++)
                drive(0, 0, 0, 3'(m), 1, vals[k]);
        drive(0, 1, 8'hFF, 0, 0, 0);
        for (int m = 0; m < 8; m++) drive(0, 0, 0, 3'(m), 1, 8'hFF);
        drive(0, 1, 8'h00, 0, 0, 0);
        for (int m = 0; m < 8; m++) drive(0, 0, 0, 3'(m), 1, 8'h00);
        idle(3);

        // Debounce to FLAG with a RISE pulse.
        drive(1, 0, 0, 0, 0, 0);
        drive(0, 1, 8'd10, 0, 0, 0);
        for (int i = 0; i < 4; i++) drive(0, 0, 0, 3'd0, 1, 8'd11);
        idle(3);

        // Gaps do not break a run; a miss does.
        drive(1, 0, 0, 0, 0, 0);
        drive(0, 1, 8'd10, 0, 0, 0);
        for (int i = 0; i < 3; i++) drive(0, 0, 0, 3'd0, 1, 8'd11);
        idle(2);
        drive(0, 0, 0, 3'd0, 1, 8'd11);
        idle(2);
        drive(1, 0, 0, 0, 0, 0);
        drive(0, 1, 8'd10, 0, 0, 0);
        drive(0, 0, 0, 3'd0, 1, 8'd11);
        drive(0, 0, 0, 3'd0, 1, 8'd11);
        drive(0, 0, 0, 3'd0, 1, 8'd9);
        drive(0, 0, 0, 3'd0, 1, 8'd11);
        idle(3);

        // Threshold write colliding with a sample.
        drive(0, 1, 8'd20, 0, 0, 0);
        drive(0, 1, 8'd50, 3'd0, 1, 8'd30);
        drive(0, 0, 0, 3'd0, 1, 8'd30);
        idle(2);

        // Clearing by misses, then reset while alarmed.
        drive(0, 1, 8'd10, 0, 0, 0);
        for (int i = 0; i < 5; i++) drive(0, 0, 0, 3'd0, 1, 8'd11);
        for (int i = 0; i < 5; i++) drive(0, 0, 0, 3'd0, 1, 8'd5);
        for (int i = 0; i < 5; i++) drive(0, 0, 0, 3'd0, 1, 8'd11);
        drive(0, 0, 0, 3'd0, 1, 8'd5);
        drive(0, 0, 0, 3'd0, 1, 8'd11);
        idle(1);
        drive(1, 0, 0, 3'd0, 1, 8'd11);
        idle(2);

        // Random bursts with a steady mode so runs of hits and misses both occur.
        for (int b = 0; b < 60; b++) begin
            mode = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 19) == 0)
                drive(1, 0, 0, 0, 0, 0);
            if ($urandom_range(0, 2) == 0)
                drive(0, 1, W'($urandom), 0, 0, 0);
            for (int i = 0; i < 8; i++) begin
                case ($urandom_range(0, 5))
                    0: a = drv_thr;
                    1: a = drv_thr + 8'd1;
                    2: a = drv_thr - 8'd1;
                    3: a = 8'h00;
                    4: a = 8'hFF;
                    default: a = W'($urandom);
                endcase
                drive(0, ($urandom_range(0, 15) == 0), W'($urandom), mode,
                      ($urandom_range(0, 3) != 0), a);
            end
        end
        idle(4);
        chk("queue_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
